spi_adc_responder: RTL and testbench

- Clocked SPI slave that emulates the two-channel 12-bit ADC on the `SPI_SCK`/`SPI_AD`/`SPI_DIN`/`SPI_DOUT` bus.
- Answers the ADC controller's command frames with caller-supplied sample values, so the accelerator and CDS paths can be exercised in simulation and in on-board bring-up without the physical converter.
- All bus inputs are oversampled in the system clock domain.

---
 rtl/spi_adc_responder.sv | 251 +++++++++++++++++++++++++
 tb/tb_spi_adc_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_adc_responder.sv
// spi_adc_responder: SPI mode-0 slave emulating a two-channel ADC; optional LSB-first trailer via SPI_RESP_LSBF_EN.
// Latency: SYNC_STAGES+1 clk from any bus pin edge to its action; miso/miso_oe settle 1 clk after that action.
// Backpressure: none; the master must honour minimum sck high/low times and the cs_n setup time.
module spi_adc_responder #(
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] ch0_val,
  input  logic [DATA_W-1:0] ch1_val,
  output logic              frame_done,
  output logic              last_ch,
  output logic              cmd_err
);

  // Counter must reach 2*DATA_W-1 when the LSB-first trailer is enabled.
  localparam int CNT_W = $clog2(2 * DATA_W) + 1;

  localparam logic [CNT_W-1:0] ZERO_C  = '0;
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);
  localparam logic [CNT_W-1:0] THREE_C = CNT_W'(3);
  localparam logic [CNT_W-1:0] DW_C    = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] DW_M1_C = CNT_W'(DATA_W - 1);
`ifdef SPI_RESP_LSBF_EN
  localparam logic [CNT_W-1:0] TRAIL_C = CNT_W'(2 * DATA_W - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_NULL,
    ST_DATA,
    ST_WAIT_CS
  } state_t;

  // Front end (SYNC_STAGES is assumed to be at least 2)
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;

  // Frame state
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      ch0_snap_q, ch0_snap_d;
  logic [DATA_W-1:0]      ch1_snap_q, ch1_snap_d;
  logic                   odd_q, odd_d;
`ifdef SPI_RESP_LSBF_EN
  logic                   msbf_q, msbf_d;
`endif
  logic                   miso_q, miso_d;
  logic                   miso_oe_q, miso_oe_d;
  logic                   frame_done_q, frame_done_d;
  logic                   last_ch_q, last_ch_d;
  logic                   cmd_err_q, cmd_err_d;

  // Data path helpers
  logic [DATA_W-1:0]      data_word;
  logic [CNT_W-1:0]       bit_idx;
  logic [DATA_W-1:0]      bit_mask;
  logic                   data_bit;
  logic [CNT_W-1:0]       total_bits;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise =  sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s &  sck_prev_q;
  assign cs_rise  =  cs_s  & ~cs_prev_q;
  assign cs_fall  = ~cs_s  &  cs_prev_q;

  // Word and bit being sent: MSB first for the first DATA_W bits, then bits 1.. upward for the trailer.
  assign data_word = odd_q ? ch1_snap_q : ch0_snap_q;
  assign bit_idx   = (cnt_q < DW_C) ? (DW_M1_C - cnt_q) : (cnt_q - DW_M1_C);
  assign bit_mask  = DATA_W'(1) << bit_idx;
  assign data_bit  = |(data_word & bit_mask);
`ifdef SPI_RESP_LSBF_EN
  assign total_bits = msbf_q ? DW_C : TRAIL_C;
`else
  assign total_bits = DW_C;
`endif

  assign miso       = miso_q;
  assign miso_oe    = miso_oe_q;
  assign frame_done = frame_done_q;
  assign last_ch    = last_ch_q;
  assign cmd_err    = cmd_err_q;

  // Synchronizer shift and one-cycle history for edge detection.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sck_prev_d  = sck_s;
    cs_prev_d   = cs_s;
  end

  // Front-end flops run free of reset so no phantom edge appears when reset releases.
  always_ff @(posedge clk) begin
    sck_sync_q  <= sck_sync_d;
    cs_sync_q   <= cs_sync_d;
    mosi_sync_q <= mosi_sync_d;
    sck_prev_q  <= sck_prev_d;
    cs_prev_q   <= cs_prev_d;
  end

  // Frame FSM next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ch0_snap_d   = ch0_snap_q;
    ch1_snap_d   = ch1_snap_q;
    odd_d        = odd_q;
`ifdef SPI_RESP_LSBF_EN
    msbf_d       = msbf_q;
`endif
    miso_d       = miso_q;
    miso_oe_d    = miso_oe_q;
    frame_done_d = 1'b0;
    last_ch_d    = last_ch_q;
    cmd_err_d    = cmd_err_q;

    case (state_q)
      ST_IDLE: begin
        miso_d    = 1'b0;
        miso_oe_d = 1'b0;
        // A coincident sck rise is dropped: the frame starts counting from the next one.
        if (cs_fall) begin
          state_d    = ST_CMD;
          cnt_d      = ZERO_C;
          ch0_snap_d = ch0_val;
          ch1_snap_d = ch1_val;
        end
      end

      ST_CMD: begin
        if (cs_rise) begin
          cmd_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (sck_rise) begin
          cnt_d = cnt_q + ONE_C;
          if (cnt_q == ZERO_C && !mosi_s) begin
            cmd_err_d = 1'b1;
            state_d   = ST_WAIT_CS;
          end
          // SGL is clocked past without effect: differential requests are served single-ended.
          if (cnt_q == TWO_C) begin
            odd_d = mosi_s;
          end
          if (cnt_q == THREE_C) begin
`ifdef SPI_RESP_LSBF_EN
            msbf_d = mosi_s;
`endif
            state_d = ST_NULL;
          end
        end
      end

      ST_NULL: begin
        if (cs_rise) begin
          cmd_err_d = 1'b1;
          state_d   = ST_IDLE;
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
        end else if (sck_fall) begin
          miso_d    = 1'b0;
          miso_oe_d = 1'b1;
          cnt_d     = ZERO_C;
          state_d   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (cs_rise) begin
          cmd_err_d = 1'b1;
          state_d   = ST_IDLE;
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
        end else if (sck_fall && cnt_q < total_bits) begin
          miso_d = data_bit;
          cnt_d  = cnt_q + ONE_C;
        end else if (sck_rise && cnt_q == total_bits) begin
          // Last bit has now been sampled by the master.
          frame_done_d = 1'b1;
          last_ch_d    = odd_q;
          miso_d       = 1'b0;
          miso_oe_d    = 1'b0;
          state_d      = ST_WAIT_CS;
        end
      end

      ST_WAIT_CS: begin
        miso_d    = 1'b0;
        miso_oe_d = 1'b0;
        if (cs_rise) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        miso_d    = 1'b0;
        miso_oe_d = 1'b0;
      end
    endcase
  end

  // Frame state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= ZERO_C;
      ch0_snap_q   <= '0;
      ch1_snap_q   <= '0;
      odd_q        <= 1'b0;
`ifdef SPI_RESP_LSBF_EN
      msbf_q       <= 1'b1;
`endif
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      frame_done_q <= 1'b0;
      last_ch_q    <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ch0_snap_q   <= ch0_snap_d;
      ch1_snap_q   <= ch1_snap_d;
      odd_q        <= odd_d;
`ifdef SPI_RESP_LSBF_EN
      msbf_q       <= msbf_d;
`endif
      miso_q       <= miso_d;
      miso_oe_q    <= miso_oe_d;
      frame_done_q <= frame_done_d;
      last_ch_q    <= last_ch_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

endmodule

// File: tb/tb_spi_adc_responder.sv
// tb_spi_adc_responder: drives SPI master frames (directed + random) and scores them against a bit-list model.
// Latency: frames are scored after cs_n release plus a settle window.
// Backpressure: not applicable; the master paces itself by clk counts.
module tb_spi_adc_responder;

  localparam int DATA_W = 12;
  localparam int SYNC   = 2;
`ifdef SPI_RESP_LSBF_EN
  localparam bit LSBF_BUILD = 1'b1;
`else
  localparam bit LSBF_BUILD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              sck;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] ch0_val;
  logic [DATA_W-1:0] ch1_val;
  logic              frame_done;
  logic              last_ch;
  logic              cmd_err;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int oe_cnt = 0;
  bit exp_err = 1'b0;
  bit exp_last = 1'b0;
  logic rx_bits [0:63];
  logic rx_oe   [0:63];
  logic [DATA_W-1:0] chg0, chg1;

  spi_adc_responder #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst        (rst),
    .sck        (sck),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .ch0_val    (ch0_val),
    .ch1_val    (ch1_val),
    .frame_done (frame_done),
    .last_ch    (last_ch),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  // Count frame_done cycles and miso_oe-high cycles away from the active edge.
  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (miso_oe === 1'b1) oe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame length in sck cycles: command + null + data (+ trailer).
  function automatic int frame_len(input logic [3:0] cmd);
    if (LSBF_BUILD && !cmd[0]) return 4 + 1 + 2 * DATA_W - 1;
    return 4 + 1 + DATA_W;
  endfunction

  // Expected serial stream packed MSB-first: null 0, word MSB..LSB, optional bits 1..DATA_W-1.
  function automatic logic [31:0] exp_word(input logic [3:0] cmd, input logic [DATA_W-1:0] v);
    logic [31:0] w;
    w = 32'd0;
    for (int b = DATA_W - 1; b >= 0; b--) w = {w[30:0], v[b]};
    if (LSBF_BUILD && !cmd[0])
      for (int b = 1; b < DATA_W; b++) w = {w[30:0], v[b]};
    return w;
  endfunction

  // Mode-0 master: mosi set while sck low, miso sampled just before each rising edge.
  task automatic master(input logic [3:0] cmd, input int half, input int ncyc, input int chg_at);
    cs_n = 1'b0;
    mosi = cmd[3];
    wait_clk(half);
    for (int i = 1; i <= ncyc; i++) begin
      rx_bits[i] = miso;
      rx_oe[i]   = miso_oe;
      sck = 1'b1;
      wait_clk(half);
      sck = 1'b0;
      mosi = (i < 4) ? cmd[3 - i] : 1'($urandom);
      if (i == chg_at) begin
        ch0_val = chg0;
        ch1_val = chg1;
      end
      wait_clk(half);
    end
    cs_n = 1'b1;
  endtask

  task automatic frame(input logic [3:0] cmd, input logic [DATA_W-1:0] v0, input logic [DATA_W-1:0] v1,
                       input logic [DATA_W-1:0] nv0, input logic [DATA_W-1:0] nv1,
                       input int half, input int extra, input int chg_at, input int abort_at,
                       input string tag);
    int len, d0, o0;
    logic [DATA_W-1:0] v;
    logic [31:0] gotw;
    logic oe_ok;
    ch0_val = v0;
    ch1_val = v1;
    chg0 = nv0;
    chg1 = nv1;
    wait_clk(2);
    v   = cmd[1] ? v1 : v0;
    len = frame_len(cmd);
    d0  = done_cnt;
    o0  = oe_cnt;
    if (abort_at >= 0) begin
      master(cmd, half, abort_at, chg_at);
      wait_clk(SYNC + 2);
      check({tag, "_abort_oe"}, 32'(miso_oe), 32'd0);
      wait_clk(8);
      exp_err = 1'b1;
      check({tag, "_abort_done"}, 32'(done_cnt - d0), 32'd0);
    end else begin
      master(cmd, half, len + extra, chg_at);
      wait_clk(10);
      if (!cmd[3]) begin
        exp_err = 1'b1;
        check({tag, "_badstart_oe"}, 32'(oe_cnt - o0), 32'd0);
        check({tag, "_badstart_done"}, 32'(done_cnt - d0), 32'd0);
      end else begin
        gotw  = 32'd0;
        oe_ok = 1'b1;
        for (int i = 5; i <= len; i++) begin
          gotw  = {gotw[30:0], rx_bits[i]};
          oe_ok = oe_ok & rx_oe[i];
        end
        exp_last = cmd[1];
        check({tag, "_rx"}, gotw, exp_word(cmd, v));
        check({tag, "_oe"}, 32'(oe_ok), 32'd1);
        check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
      end
    end
    check({tag, "_last_ch"}, 32'(last_ch), 32'(exp_last));
    check({tag, "_cmd_err"}, 32'(cmd_err), 32'(exp_err));
    check({tag, "_idle_oe"}, 32'(miso_oe), 32'd0);
  endtask

  initial begin
    int d0;
    rst = 1'b0;
    sck = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    ch0_val = '0;
    ch1_val = '0;
    chg0 = '0;
    chg1 = '0;

    // Reset with sck toggling
    repeat (5) begin
      @(negedge clk);
      sck = ~sck;
    end
    sck = 1'b0;
    wait_clk(2);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_oe", 32'(miso_oe), 32'd0);
    check("rst_err", 32'(cmd_err), 32'd0);
    check("rst_last", 32'(last_ch), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    rst = 1'b1;
    wait_clk(5);

    // Directed frames
    frame(4'b1101, 12'hA5C, 12'h123, 12'hA5C, 12'h123, 8, 0, 0, -1, "ch0");
    frame(4'b1111, 12'h456, 12'h3F0, 12'h456, 12'hFFF, 8, 0, 7, -1, "ch1_chg");
    frame(4'b1001, 12'h0F0, 12'h70F, 12'h0F0, 12'h70F, 8, 2, 0, -1, "diff_extra");
    frame(4'b0111, 12'h111, 12'h222, 12'h111, 12'h222, 8, 0, 0, -1, "badstart");
    frame(4'b1101, 12'h9C3, 12'h222, 12'h9C3, 12'h222, 8, 0, 0, -1, "after_bad");
    frame(4'b1111, 12'h333, 12'hB4D, 12'h333, 12'hB4D, 8, 0, 0, 10, "abort");
`ifdef SPI_RESP_LSBF_EN
    frame(4'b1100, 12'h801, 12'h000, 12'h801, 12'h000, 8, 0, 0, -1, "lsbf");
`endif

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      logic [3:0] cmd;
      int half, mode, len, ab;
      cmd  = {1'b1, 3'($urandom)};
      half = $urandom_range(5, 10);
      mode = $urandom_range(0, 5);
      if (mode == 0) cmd[3] = 1'b0;
      len  = frame_len(cmd);
      ab   = (mode == 1) ? $urandom_range(0, len - 1) : -1;
      frame(cmd, DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom),
            half, $urandom_range(0, 2), $urandom_range(1, len), ab, "rand");
    end

    // Leave last_ch = 1 so the mid-frame reset visibly clears it
    frame(4'b1111, 12'h5A5, 12'hC3C, 12'h5A5, 12'hC3C, 6, 0, 0, -1, "pre_rst");

    // Reset mid-frame: frame abandoned silently
    d0 = done_cnt;
    fork
      master(4'b1111, 8, 17, 0);
    join_none
    wait_clk(8 + 9 * 16);
    rst = 1'b0;
    wait_clk(3);
    check("midrst_oe", 32'(miso_oe), 32'd0);
    check("midrst_miso", 32'(miso), 32'd0);
    check("midrst_last", 32'(last_ch), 32'd0);
    rst = 1'b1;
    wait fork;
    wait_clk(10);
    exp_err  = 1'b0;
    exp_last = 1'b0;
    check("midrst_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_err", 32'(cmd_err), 32'd0);
    frame(4'b1111, 12'h0AB, 12'hE71, 12'h0AB, 12'hE71, 7, 1, 0, -1, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
